spi_rom_reader: RTL

SPI_ROM_READER -- requirements
Module: spi_rom_reader

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_clkgen.sv | 26 ++
 rtl/spi_rom_reader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI ROM reader: FSM states, SPI mode 3, default divider.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLow,
    StHigh,
    StHold,
    StFinish
  } state_e;

  localparam bit Cpol = 1'b1;
  localparam bit Cpha = 1'b1;

  localparam int unsigned ClkDivDefault = 2;

endpackage

// File: rtl/spi_clkgen.sv
// Half-period timer: restarts from zero on load and flags the last cycle of a CLKDIV-long phase.
module spi_clkgen #(
  parameter int unsigned ClkDiv = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic tick_o
);

  logic [7:0] cnt_q;

  assign tick_o = (cnt_q == 8'(ClkDiv - 1));

  // Saturates at the tick value so an idle state keeps reporting expiry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (!tick_o) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/spi_rom_reader.sv
// SPI mode-3 ROM reader: clocks len bytes in MSB first and hands them out on a valid/ready port.
// Define SPI_READER_CMD_EN to add a cmd byte shifted out on mosi ahead of the data bytes.
module spi_rom_reader
  import spi_pkg::*;
#(
  parameter int unsigned CLKDIV = ClkDivDefault,
  parameter int unsigned LENW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [LENW-1:0] len,
`ifdef SPI_READER_CMD_EN
  input  logic [7:0]      cmd,
`endif
  output logic            busy,
  output logic            done,
  output logic [7:0]      data,
  output logic            valid,
  input  logic            ready,
  output logic            ss,
  output logic            sclk,
  output logic            mosi,
  input  logic            miso
);

  // With CPHA=1 the sampling edge is the trailing one, i.e. the edge that leaves LOW.
  localparam state_e SampleFrom = Cpha ? StLow : StHigh;

  state_e state_q, state_d;
  logic            busy_q, done_q, valid_q, ss_q, sclk_q;
  logic [7:0]      data_q, shift_q;
  logic [2:0]      bit_q;
  logic [LENW-1:0] count_q;
  logic            tick, load, accept, sample_en, hold_entry, hs;
  logic            cmd_phase_q;

  spi_clkgen #(
    .ClkDiv (CLKDIV)
  ) u_clkgen (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (load),
    .tick_o (tick)
  );

  assign accept = (state_q == StIdle) && start && (len != '0);
  assign hs     = valid_q && ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StSetup;
      StSetup:  if (tick) state_d = StLow;
      StLow:    if (tick) state_d = StHigh;
      // bit_q wraps to zero once the eighth bit has been sampled.
      StHigh:   if (tick) state_d = (bit_q == 3'd0 && !cmd_phase_q) ? StHold : StLow;
      StHold:   if (hs) state_d = (count_q != '0) ? StLow : StFinish;
      StFinish: if (tick) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign load       = (state_d != state_q);
  assign sample_en  = (state_q == SampleFrom) && load;
  assign hold_entry = (state_q == StHigh) && (state_d == StHold);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ss_q    <= 1'b1;
      sclk_q  <= Cpol;
      shift_q <= '0;
      bit_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
      ss_q    <= !(state_d inside {StSetup, StLow, StHigh, StHold});
      sclk_q  <= (state_d == StLow) ? ~Cpol : Cpol;
      done_q  <= ((state_q == StFinish) && tick) ||
                 ((state_q == StIdle) && start && (len == '0));
      if (accept) begin
        count_q <= len;
        bit_q   <= '0;
      end
      if (sample_en) begin
        shift_q <= {shift_q[6:0], miso};
        bit_q   <= bit_q + 3'd1;
      end
      if (hold_entry) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
        count_q <= count_q - LENW'(1);
      end else if ((state_q == StHold) && hs) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef SPI_READER_CMD_EN
  logic [7:0] cmd_sh_q;
  logic       mosi_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_phase_q <= 1'b0;
      cmd_sh_q    <= '0;
      mosi_q      <= 1'b1;
    end else if (accept) begin
      cmd_phase_q <= 1'b1;
      cmd_sh_q    <= cmd;
    end else if (cmd_phase_q && (state_d == StLow) && load) begin
      // The falling edge after the eighth cmd bit ends the cmd phase.
      if ((state_q == StHigh) && (bit_q == 3'd0)) begin
        cmd_phase_q <= 1'b0;
        mosi_q      <= 1'b1;
      end else begin
        mosi_q   <= cmd_sh_q[7];
        cmd_sh_q <= {cmd_sh_q[6:0], 1'b0};
      end
    end
  end

  assign mosi = mosi_q;
`else
  assign cmd_phase_q = 1'b0;
  assign mosi        = 1'b1;
`endif

  assign busy  = busy_q;
  assign done  = done_q;
  assign data  = data_q;
  assign valid = valid_q;
  assign ss    = ss_q;
  assign sclk  = sclk_q;

endmodule
